tdm_demux_1x4: RTL and testbench
================================

Name: tdm_demux_1x4

Overview:
- Receive end of the 4-channel time-division link that the 4x1 mux drives.
- Accepts a bit-serial stream of frames, each carrying 4 channel slots of WIDTH bits, with a frame-sync marker on the first bit of slot 0.
- Tracks framing, deserialises each slot and presents all four channel words in parallel once per frame.
- Flags framing errors and re-acquires lock.

Parameters:
- WIDTH, 8, bits per channel slot (frame length = 4*WIDTH bits).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit, MSB of each slot first, slot 0 first.
- sin_en  input  1  sin/fsync valid this cycle; when low, all state holds.
- fsync  input  1  high with the first bit of slot 0; sampled only when sin_en=1.
- dout  output  4*WIDTH  channel k word at dout[k*WIDTH +: WIDTH].
- dout_valid  output  1  one-cycle pulse when dout has been updated with a complete frame.
- sel  output  2  slot index of the next expected bit (0..3).
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst=1 at an edge):
  - state=HUNT, bit counter=0, sel=0.
  - dout=0, dout_valid=0, locked=0, sync_err=0.
  - Any partial frame is discarded; reset mid-frame has the same effect.
- Accepted bit: a cycle with sin_en=1. Cycles with sin_en=0 change nothing; dout_valid and sync_err deassert after one cycle regardless.
- Internal frame bit counter fcnt runs 0..4*WIDTH-1 and wraps to 0.
  - sel = fcnt / WIDTH; the in-slot bit index is fcnt % WIDTH.
- HUNT state:
  - Accepted bits with fsync=0 are ignored.
  - An accepted bit with fsync=1 is stored as bit 0 of the frame (slot 0 MSB). Then fcnt=1, state=RUN, locked=1 from the next cycle.
- RUN state, accepted bit:
  - fcnt != 0 and fsync=0: shift bit into the slot (fcnt/WIDTH), then fcnt+1.
  - fcnt = 4*WIDTH-1: the last bit completes the frame.
    - On that edge, register all four slot words into dout and pulse dout_valid on the next cycle (exactly one cycle; latency 1 clock after the final bit's edge).
    - fcnt wraps to 0.
    - dout holds between frames.
  - fcnt = 0 and fsync=1: normal start of the next frame; store as bit 0, fcnt=1.
  - fcnt = 0 and fsync=0 (missing sync): pulse sync_err, state=HUNT, locked=0, bit discarded, dout unchanged.
  - fcnt != 0 and fsync=1 (early sync): pulse sync_err, abandon the partial frame (no dout_valid), treat this bit as bit 0 of a new frame, fcnt=1, stay in RUN.
- sin_en=0 together with fsync=1 is not an event.
- Back-to-back frames with sin_en held high give a dout_valid pulse every 4*WIDTH cycles with no dead cycle.
- Shift registers are not cleared between frames. Every bit of dout is overwritten from the new frame on completion.

Test Plan (WIDTH=8):
- Reset, then one frame with sin_en=1 continuously, fsync on bit 0, ch0=0xA5 ch1=0x3C ch2=0xFF ch3=0x01.
  - Response: dout=0x01FF3CA5; dout_valid high for exactly one cycle, the cycle after the 32nd bit; locked=1 from bit 1; sync_err never asserts.
- Two back-to-back frames (0x01FF3CA5, then 0x12345678 with ch0=0x78).
  - Response: two dout_valid pulses 32 cycles apart; dout=0x12345678 after the second.
- Same first frame with sin_en deasserted for 3 cycles after every 5th accepted bit, fsync toggling during the gaps.
  - Response: identical dout=0x01FF3CA5 and a single dout_valid pulse; sel advances only on accepted bits.
- Missing sync: after a good frame, send 32 bits with fsync=0 throughout.
  - Response: sync_err pulse on the first bit; locked=0; no dout_valid; dout still 0x01FF3CA5.
  - Then a good frame with fsync restores lock and dout_valid.
- Early sync: fsync=1 on bit 10 of a frame, followed by a full 32-bit frame 0xCAFEBABE.
  - Response: sync_err pulse at bit 10; locked stays 1; exactly one dout_valid, with dout=0xCAFEBABE.
- rst=1 for one cycle at bit 17 of a frame.
  - Response: next cycle dout=0, locked=0, sel=0, no dout_valid.
  - Bits without fsync are then ignored until the next fsync.

Source files
------------

// File: rtl/tdm_demux_1x4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1x4
// Brief    : Receive side of a 4-channel bit-serial TDM link. Locks onto the
//            frame-sync marker, deserialises four WIDTH-bit slots per frame
//            and presents them in parallel once per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1x4 #(
  parameter int WIDTH = 8  // must be >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_en,
  input  logic                 fsync,
  output logic [4*WIDTH-1:0]   dout,
  output logic                 dout_valid,
  output logic [1:0]           sel,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int               c_BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_BW-1:0]  c_BIT_LAST = c_BW'(WIDTH - 1);
  localparam logic [c_BW-1:0]  c_BIT_ONE  = c_BW'(1);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic [1:0]                r_slot_idx;
  logic [c_BW-1:0]           r_bit_idx;
  logic [3:0][WIDTH-1:0]     r_slot;
  logic [4*WIDTH-1:0]        r_dout;
  logic                      r_valid;
  logic                      r_err;

  logic                      w_first;
  logic                      w_last;
  logic                      w_store;
  logic [1:0]                w_dst;
  logic [WIDTH-1:0]          w_shift;
  logic [3:0][WIDTH-1:0]     w_frame;

  // fcnt is kept as {slot index, in-slot bit index} so no divider is needed.
  assign w_first = (r_slot_idx == 2'd0) && (r_bit_idx == '0);
  assign w_last  = (r_slot_idx == 2'd3) && (r_bit_idx == c_BIT_LAST);

  // A bit lands in a slot when it opens a frame or continues a locked one.
  assign w_store = sin_en && (fsync || ((r_state == ST_RUN) && !w_first));
  assign w_dst   = fsync ? 2'd0 : r_slot_idx;
  assign w_shift = {r_slot[w_dst][WIDTH-2:0], sin};

  always_comb begin
    w_frame    = r_slot;
    w_frame[3] = w_shift;
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_slot[w_dst] <= w_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_slot_idx <= 2'd0;
      r_bit_idx  <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (sin_en) begin
        case (r_state)
          ST_HUNT: begin
            if (fsync) begin
              r_state    <= ST_RUN;
              r_slot_idx <= 2'd0;
              r_bit_idx  <= c_BIT_ONE;
            end
          end
          default: begin
            if (fsync) begin
              // Sync anywhere but bit 0 abandons the partial frame.
              r_err      <= !w_first;
              r_slot_idx <= 2'd0;
              r_bit_idx  <= c_BIT_ONE;
            end else if (w_first) begin
              r_err   <= 1'b1;
              r_state <= ST_HUNT;
            end else begin
              if (r_bit_idx == c_BIT_LAST) begin
                r_bit_idx  <= '0;
                r_slot_idx <= r_slot_idx + 2'd1;
              end else begin
                r_bit_idx  <= r_bit_idx + c_BIT_ONE;
              end
              if (w_last) begin
                r_dout  <= w_frame;
                r_valid <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign sel        = r_slot_idx;
  assign locked     = (r_state == ST_RUN);
  assign sync_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_1x4
// Brief    : Self-checking bench for tdm_demux_1x4 (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1x4;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        sin_en;
  logic        fsync;
  logic [31:0] dout;
  logic        dout_valid;
  logic [1:0]  sel;
  logic        locked;
  logic        sync_err;

  tdm_demux_1x4 #(.WIDTH(WIDTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .fsync      (fsync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sel        (sel),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          gap;
    logic [31:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;
  int          t_valid[$];
  vec_t        vecs[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every completed frame must match the oldest pending frame.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      t_valid.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("unexpected dout_valid", 32'd1, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("scoreboard dout", dout, sb_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic fs, input logic en);
    sin    = b;
    fsync  = fs;
    sin_en = en;
    tick();
  endtask

  function automatic logic frame_bit(input logic [31:0] d, input int i);
    logic [31:0] v;
    v = d;
    return v[(i / 8) * 8 + 7 - (i % 8)];
  endfunction

  task automatic send_frame(input logic [31:0] d, input bit gap, input bit err0,
                            input logic [31:0] exp);
    sb_q.push_back(exp);
    for (int i = 0; i < 32; i++) begin
      drive(frame_bit(d, i), i == 0, 1'b1);
      chk("sel", 32'(sel), 32'(((i + 1) % 32) / 8));
      chk("locked", 32'(locked), 32'd1);
      chk("sync_err", 32'(sync_err), 32'(i == 0 && err0));
      chk("dout_valid timing", 32'(dout_valid), 32'(i == 31));
      if (i == 31) chk("frame dout", dout, exp);
      if (gap && (i % 5 == 4) && i != 31) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'($urandom), g % 2 == 0, 1'b0);
          chk("gap sel", 32'(sel), 32'(((i + 1) % 32) / 8));
          chk("gap valid", 32'(dout_valid), 32'd0);
          chk("gap sync_err", 32'(sync_err), 32'd0);
        end
      end
    end
  endtask

  task automatic send_partial(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      drive(frame_bit(d, i), i == 0, 1'b1);
      chk("partial valid", 32'(dout_valid), 32'd0);
      chk("partial sync_err", 32'(sync_err), 32'd0);
      chk("partial locked", 32'(locked), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 32'h01FF3CA5, gap: 1'b0, exp: 32'h01FF3CA5};
    vecs[1] = '{data: 32'h12345678, gap: 1'b0, exp: 32'h12345678};
    vecs[2] = '{data: 32'h01FF3CA5, gap: 1'b1, exp: 32'h01FF3CA5};

    rst = 1'b1; sin = 1'b0; sin_en = 1'b0; fsync = 1'b0;
    tick();
    tick();
    chk("reset dout", dout, 32'd0);
    chk("reset valid", 32'(dout_valid), 32'd0);
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset sel", 32'(sel), 32'd0);
    chk("reset sync_err", 32'(sync_err), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back frames, then the gapped frame, all without idle cycles.
    for (int k = 0; k < 3; k++) begin
      send_frame(vecs[k].data, vecs[k].gap, 1'b0, vecs[k].exp);
    end

    // Missing sync at a frame boundary drops lock and discards the bits.
    for (int i = 0; i < 32; i++) begin
      drive(1'($urandom), 1'b0, 1'b1);
      chk("nosync sync_err", 32'(sync_err), 32'(i == 0));
      chk("nosync locked", 32'(locked), 32'd0);
      chk("nosync valid", 32'(dout_valid), 32'd0);
      chk("nosync sel", 32'(sel), 32'd0);
    end
    chk("nosync dout held", dout, 32'h01FF3CA5);
    send_frame(32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D);

    // Early sync on bit 10 restarts the frame while staying locked.
    send_partial(32'h11111111, 10);
    send_frame(32'hCAFEBABE, 1'b0, 1'b1, 32'hCAFEBABE);

    // Reset at bit 17 of a frame.
    send_partial(32'h55AA55AA, 17);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    chk("midrst dout", dout, 32'd0);
    chk("midrst locked", 32'(locked), 32'd0);
    chk("midrst sel", 32'(sel), 32'd0);
    chk("midrst valid", 32'(dout_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 1'b0, 1'b1);
      chk("hunt locked", 32'(locked), 32'd0);
      chk("hunt sel", 32'(sel), 32'd0);
      chk("hunt valid", 32'(dout_valid), 32'd0);
      chk("hunt sync_err", 32'(sync_err), 32'd0);
    end
    send_frame(32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF);

    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    chk("dout_valid pulse count", 32'(t_valid.size()), 32'd6);
    if (t_valid.size() >= 2) chk("back-to-back spacing", 32'(t_valid[1] - t_valid[0]), 32'd32);
    else chk("back-to-back pulses seen", 32'(t_valid.size()), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
